// File: rtl/decode_pkg.sv
// Shared RV32I decode constants, stored-entry layout and queue state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package decode_pkg;

    // ALU operation codes carried with each decoded entry
    localparam logic [4:0] ALU_LUI   = 5'b00000;
    localparam logic [4:0] ALU_AUIPC = 5'b00001;
    localparam logic [4:0] ALU_ADD   = 5'b00010;
    localparam logic [4:0] ALU_BEQ   = 5'b00011;
    localparam logic [4:0] ALU_BNE   = 5'b00100;
    localparam logic [4:0] ALU_BLT   = 5'b00101;
    localparam logic [4:0] ALU_BGE   = 5'b00110;
    localparam logic [4:0] ALU_BLTU  = 5'b00111;
    localparam logic [4:0] ALU_BGEU  = 5'b01000;
    localparam logic [4:0] ALU_SLT   = 5'b01001;
    localparam logic [4:0] ALU_SLTU  = 5'b01010;
    localparam logic [4:0] ALU_XOR   = 5'b01011;
    localparam logic [4:0] ALU_OR    = 5'b01100;
    localparam logic [4:0] ALU_AND   = 5'b01101;
    localparam logic [4:0] ALU_SLL   = 5'b01110;
    localparam logic [4:0] ALU_SRL   = 5'b01111;
    localparam logic [4:0] ALU_SRA   = 5'b10000;
    localparam logic [4:0] ALU_SUB   = 5'b10001;
    localparam logic [4:0] ALU_FENCE = 5'b10010;
    localparam logic [4:0] ALU_ILL   = 5'b11111;

    // Immediate format selectors
    localparam logic [2:0] IMM_U    = 3'b000;
    localparam logic [2:0] IMM_J    = 3'b001;
    localparam logic [2:0] IMM_I    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_S    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b101;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [2:0]  immsel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } entry_t;

endpackage

// File: rtl/decode_queue_if.sv
// Instruction-in / decoded-entry-out handshake bundle for decode_queue.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; the consumer stalls the queue via out_ready.
interface decode_queue_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_alu_op;
    logic [2:0]      out_immsel;
    logic [31:0]     out_imm;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal;

    // Decoder side
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu_op, out_immsel, out_imm,
               out_rd, out_rs1, out_rs2, out_pc, out_illegal
    );

    // Fetch / execute side
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_op, out_immsel, out_imm,
               out_rd, out_rs1, out_rs2, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_gen.sv
// Builds the sign-extended 32-bit immediate for the selected RV32I format.
// Latency: purely combinational.
// Backpressure: none.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [2:0]  immsel_i,
    output logic [31:0] imm_o
);
    // Opcode bits never feed an immediate
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    // Format mux; non-immediate formats yield zero
    always_comb begin
        imm_o = 32'h0;
        case (immsel_i)
            IMM_U: imm_o = {instr_i[31:12], 12'h000};
            IMM_J: imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_B: imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            default: imm_o = 32'h0;
        endcase
    end
endmodule

// File: rtl/decode_queue.sv
// RV32I decoder feeding a DEPTH-entry FIFO; SYSTEM opcodes drain the queue and halt.
// Latency: 1 cycle from accept to out_valid; no combinational in-to-out path.
// Backpressure: in_ready drops when full (even if popping) or once draining/halted.
// Build option DECODE_ILLEGAL_EN: enqueue unrecognised encodings flagged illegal.
module decode_queue
    import decode_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int PC_W  = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    decode_queue_if.slave  io,
    output logic           halt,
    output logic [CW-1:0]  count
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = io.in_instr[6:0];
    assign f3     = io.in_instr[14:12];
    assign f7     = io.in_instr[31:25];

    logic [4:0]  d_alu;
    logic [2:0]  d_immsel;
    logic        d_legal;
    logic        d_fence;
    logic [31:0] gen_imm;
    entry_t      d_entry;

    // Opcode/funct decode; anything not matched stays ALU_ILL / IMM_NONE
    always_comb begin
        d_alu    = ALU_ILL;
        d_immsel = IMM_NONE;
        d_legal  = 1'b0;
        d_fence  = 1'b0;
        case (opcode)
            OPC_LUI:   begin d_alu = ALU_LUI;   d_immsel = IMM_U; d_legal = 1'b1; end
            OPC_AUIPC: begin d_alu = ALU_AUIPC; d_immsel = IMM_U; d_legal = 1'b1; end
            OPC_JAL:   begin d_alu = ALU_ADD;   d_immsel = IMM_J; d_legal = 1'b1; end
            OPC_JALR: if (f3 == 3'b000) begin
                d_alu = ALU_ADD; d_immsel = IMM_I; d_legal = 1'b1;
            end
            OPC_BRANCH: begin
                d_legal = 1'b1;
                case (f3)
                    3'b000:  d_alu = ALU_BEQ;
                    3'b001:  d_alu = ALU_BNE;
                    3'b100:  d_alu = ALU_BLT;
                    3'b101:  d_alu = ALU_BGE;
                    3'b110:  d_alu = ALU_BLTU;
                    3'b111:  d_alu = ALU_BGEU;
                    default: d_legal = 1'b0;
                endcase
                if (d_legal) d_immsel = IMM_B;
            end
            OPC_LOAD: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                d_alu = ALU_ADD; d_immsel = IMM_I; d_legal = 1'b1;
            end
            OPC_STORE: if (f3 <= 3'b010) begin
                d_alu = ALU_ADD; d_immsel = IMM_S; d_legal = 1'b1;
            end
            OPC_OPIMM: begin
                d_legal = 1'b1;
                case (f3)
                    3'b000: d_alu = ALU_ADD;
                    3'b010: d_alu = ALU_SLT;
                    3'b011: d_alu = ALU_SLTU;
                    3'b100: d_alu = ALU_XOR;
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                    3'b001: if (f7 == F7_BASE) d_alu = ALU_SLL; else d_legal = 1'b0;
                    default: begin
                        if (f7 == F7_BASE)     d_alu = ALU_SRL;
                        else if (f7 == F7_ALT) d_alu = ALU_SRA;
                        else                   d_legal = 1'b0;
                    end
                endcase
                if (d_legal) d_immsel = IMM_I;
                else         d_alu    = ALU_ILL;
            end
            OPC_OP: begin
                d_legal = 1'b1;
                if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      d_alu = ALU_SUB;
                    else if (f3 == 3'b101) d_alu = ALU_SRA;
                    else                   d_legal = 1'b0;
                end else if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  d_alu = ALU_ADD;
                        3'b001:  d_alu = ALU_SLL;
                        3'b010:  d_alu = ALU_SLT;
                        3'b011:  d_alu = ALU_SLTU;
                        3'b100:  d_alu = ALU_XOR;
                        3'b101:  d_alu = ALU_SRL;
                        3'b110:  d_alu = ALU_OR;
                        default: d_alu = ALU_AND;
                    endcase
                end else begin
                    d_legal = 1'b0;
                end
                if (!d_legal) d_alu = ALU_ILL;
            end
            OPC_MISC: if (f3 == 3'b000) begin
                d_alu = ALU_FENCE; d_immsel = IMM_I; d_legal = 1'b1; d_fence = 1'b1;
            end
            default: ;
        endcase
    end

    imm_gen u_imm_gen (
        .instr_i  (io.in_instr),
        .immsel_i (d_immsel),
        .imm_o    (gen_imm)
    );

    // Pack the decoded fields; FENCE carries an I-format slot with a zero immediate
    always_comb begin
        d_entry        = '0;
        d_entry.alu_op = d_alu;
        d_entry.immsel = d_immsel;
        d_entry.imm    = d_fence ? 32'h0 : gen_imm;
        d_entry.rd     = io.in_instr[11:7];
        d_entry.rs1    = io.in_instr[19:15];
        d_entry.rs2    = io.in_instr[24:20];
    end

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];
    logic [PC_W-1:0] pc_q  [DEPTH];
    logic            accept, is_system, push, pop;

    assign is_system = (opcode == OPC_SYSTEM);
    assign accept    = io.in_valid && io.in_ready;
    assign pop       = io.out_valid && io.out_ready;
`ifdef DECODE_ILLEGAL_EN
    assign push      = accept && !is_system;
`else
    // Unrecognised encodings are swallowed: accepted but never stored
    assign push      = accept && !is_system && d_legal;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // FSM next state: SYSTEM accepted in RUN drains; an empty queue in DRAIN halts for good
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (accept && is_system) state_d = ST_DRAIN;
            ST_DRAIN: if (count_q == '0)       state_d = ST_HALTED;
            default:  state_d = ST_HALTED;
        endcase
    end

    // FSM outputs: input handshake gated by fullness and run state
    always_comb begin
        io.in_ready = (count_q < FULL) && (state_q == ST_RUN);
        halt        = (state_q == ST_HALTED);
    end

    // Pointer and occupancy next state; pointers wrap naturally at power-of-two DEPTH
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= d_entry;
                pc_q[wr_ptr_q]  <= io.in_pc;
            end
        end
    end

`ifdef DECODE_ILLEGAL_EN
    logic ill_q [DEPTH];

    // Illegal flag travels alongside each stored entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ill_q[i] <= 1'b0;
        end else if (push) begin
            ill_q[wr_ptr_q] <= !d_legal;
        end
    end
    assign io.out_illegal = ill_q[rd_ptr_q];
`else
    assign io.out_illegal = 1'b0;
`endif

    assign io.out_valid  = (count_q != '0);
    assign io.out_alu_op = mem_q[rd_ptr_q].alu_op;
    assign io.out_immsel = mem_q[rd_ptr_q].immsel;
    assign io.out_imm    = mem_q[rd_ptr_q].imm;
    assign io.out_rd     = mem_q[rd_ptr_q].rd;
    assign io.out_rs1    = mem_q[rd_ptr_q].rs1;
    assign io.out_rs2    = mem_q[rd_ptr_q].rs2;
    assign io.out_pc     = pc_q[rd_ptr_q];
    assign count         = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2): decode fields, fill/wrap, halt, reset.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: out_ready is driven explicitly per step.
module tb_decode_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       halt;
    logic [1:0] count;
    int         n_chk  = 0;
    int         n_fail = 0;

    decode_queue_if #(.PC_W(32)) dif ();

    decode_queue #(.DEPTH(2), .PC_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .io    (dif.slave),
        .halt  (halt),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        dif.in_valid = 1'b1;
        dif.in_instr = instr;
        dif.in_pc    = pc;
        tick();
        dif.in_valid = 1'b0;
    endtask

    task automatic pop();
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.in_instr  = 32'h0;
        dif.in_pc     = 32'h0;
        dif.out_ready = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", dif.out_valid, 0);
        chk("rst_halt", halt, 0);
        chk("rst_in_ready", dif.in_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ADDI x1,x0,5
        dif.in_valid = 1'b1;
        dif.in_instr = 32'h00500093;
        dif.in_pc    = 32'h00000100;
        #1;
        chk("addi_no_comb_path", dif.out_valid, 0);
        tick();
        dif.in_valid = 1'b0;
        chk("addi_valid", dif.out_valid, 1);
        chk("addi_alu", dif.out_alu_op, 5'b00010);
        chk("addi_immsel", dif.out_immsel, 3'b010);
        chk("addi_imm", dif.out_imm, 32'h00000005);
        chk("addi_rd", dif.out_rd, 1);
        chk("addi_rs1", dif.out_rs1, 0);
        chk("addi_pc", dif.out_pc, 32'h100);
        chk("addi_count", count, 1);
        chk("addi_illegal", dif.out_illegal, 0);
        pop();
        chk("addi_popped", count, 0);

        // SUB x3,x1,x2 then BEQ -4
        push(32'h402081B3, 32'h200);
        push(32'hFE000EE3, 32'h204);
        chk("sub_count", count, 2);
        chk("sub_alu", dif.out_alu_op, 5'b10001);
        chk("sub_immsel", dif.out_immsel, 3'b101);
        chk("sub_rd", dif.out_rd, 3);
        chk("sub_rs1", dif.out_rs1, 1);
        chk("sub_rs2", dif.out_rs2, 2);
        pop();
        chk("beq_alu", dif.out_alu_op, 5'b00011);
        chk("beq_immsel", dif.out_immsel, 3'b011);
        chk("beq_imm", dif.out_imm, 32'hFFFFFFFC);
        chk("beq_pc", dif.out_pc, 32'h204);
        pop();
        chk("beq_popped", count, 0);

        // Fill with in_valid held, third instruction must wait
        dif.in_valid = 1'b1;
        dif.in_instr = 32'h00100093;
        tick();
        dif.in_instr = 32'h00200113;
        chk("fill_ready_1", dif.in_ready, 1);
        tick();
        dif.in_instr = 32'h00300193;
        chk("fill_count_2", count, 2);
        chk("fill_ready_full", dif.in_ready, 0);
        tick();
        chk("fill_hold_count", count, 2);
        chk("fill_head_rd", dif.out_rd, 1);
        dif.out_ready = 1'b1;
        #1;
        chk("full_pop_no_ready", dif.in_ready, 0);
        tick();
        chk("fill_after_pop_count", count, 1);
        chk("fill_second_rd", dif.out_rd, 2);
        chk("fill_second_imm", dif.out_imm, 32'h2);
        tick();
        chk("pushpop_count", count, 1);
        chk("wrap_third_rd", dif.out_rd, 3);
        chk("wrap_third_imm", dif.out_imm, 32'h3);
        dif.in_valid = 1'b0;
        tick();
        dif.out_ready = 1'b0;
        chk("fill_drained", count, 0);

        // LUI x1,0x12345 and SW x1,-4(x2)
        push(32'h123450B7, 32'h300);
        chk("lui_alu", dif.out_alu_op, 5'b00000);
        chk("lui_immsel", dif.out_immsel, 3'b000);
        chk("lui_imm", dif.out_imm, 32'h12345000);
        pop();
        push(32'hFE112E23, 32'h304);
        chk("sw_alu", dif.out_alu_op, 5'b00010);
        chk("sw_immsel", dif.out_immsel, 3'b100);
        chk("sw_imm", dif.out_imm, 32'hFFFFFFFC);
        chk("sw_rs1", dif.out_rs1, 2);
        chk("sw_rs2", dif.out_rs2, 1);
        pop();

        // Unrecognised encodings: all-ones and ADD with funct7=0000001
        dif.in_valid = 1'b1;
        dif.in_instr = 32'hFFFFFFFF;
        #1;
        chk("ill_ready", dif.in_ready, 1);
        tick();
        dif.in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        chk("ill_count", count, 1);
        chk("ill_flag", dif.out_illegal, 1);
        chk("ill_alu", dif.out_alu_op, 5'b11111);
        chk("ill_immsel", dif.out_immsel, 3'b101);
        pop();
        push(32'h022081B3, 32'h400);
        chk("f7_bad_alu", dif.out_alu_op, 5'b11111);
        pop();
`else
        chk("ill_dropped", count, 0);
        chk("ill_no_valid", dif.out_valid, 0);
        push(32'h022081B3, 32'h400);
        chk("f7_bad_dropped", count, 0);
`endif

        // One entry queued, then ECALL drains and halts
        push(32'h00100093, 32'h500);
        push(32'h00000073, 32'h504);
        chk("ecall_ready", dif.in_ready, 0);
        chk("ecall_not_queued", count, 1);
        chk("ecall_halt0", halt, 0);
        tick();
        chk("drain_halt0", halt, 0);
        pop();
        chk("drain_empty", count, 0);
        chk("drain_halt_pending", halt, 0);
        tick();
        chk("halted", halt, 1);
        dif.in_valid = 1'b1;
        dif.in_instr = 32'h00100093;
        tick();
        tick();
        dif.in_valid = 1'b0;
        chk("halted_sticky", halt, 1);
        chk("halted_ready", dif.in_ready, 0);
        chk("halted_count", count, 0);

        // Reset out of HALTED, then reset asynchronously mid-DRAIN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("unhalt", halt, 0);
        chk("unhalt_ready", dif.in_ready, 1);
        push(32'h00100093, 32'h600);
        push(32'h00000073, 32'h604);
        chk("drain2_count", count, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_out_valid", dif.out_valid, 0);
        chk("arst_ready", dif.in_ready, 1);
        rst = 1'b0;
        tick();
        chk("post_rst_count", count, 0);
        chk("post_rst_halt", halt, 0);
        chk("post_rst_ready", dif.in_ready, 1);
        push(32'h00100093, 32'h700);
        chk("post_rst_valid", dif.out_valid, 1);
        chk("post_rst_rd", dif.out_rd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH: default 2; decoded-entry buffer depth; power of two, at least 2.
REQ-002 Parameter PC_W: default 32; program-counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_instr/in_pc valid.
REQ-006 in_ready  output  1  block accepts an instruction this cycle.
REQ-007 in_instr  input  32  RV32I instruction word.
REQ-008 in_pc  input  PC_W  instruction address.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer takes head entry.
REQ-011 out_alu_op  output  5  ALU operation code.
REQ-012 out_immsel  output  3  immediate format code.
REQ-013 out_imm  output  32  sign-extended immediate.
REQ-014 out_rd, out_rs1, out_rs2  output  5 each  register indices.
REQ-015 out_pc  output  PC_W  address of head entry.
REQ-016 out_illegal  output  1  head entry is an unrecognised encoding.
REQ-017 halt  output  1  sticky; core halted by ECALL/EBREAK.
REQ-018 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 Decode is combinational on in_instr; the decoded entry is written into the FIFO when in_valid && in_ready.
REQ-020 Latency: an entry accepted into an empty queue at edge N shall give out_valid=1 after edge N; there is no combinational in-to-out path.
REQ-021 A pop occurs when out_valid && out_ready; a push and a pop in the same cycle leave count unchanged.
REQ-022 in_ready = (count < DEPTH) && state==RUN; when full, in_ready=0 even if a pop happens in the same cycle.
REQ-023 Read and write pointers wrap modulo DEPTH; out_* values are don't-care when out_valid=0.
REQ-024 ALU codes: LUI 00000, AUIPC 00001, ADD/ADDI/JAL/JALR/loads/stores 00010, BEQ 00011, BNE 00100, BLT 00101, BGE 00110, BLTU 00111, BGEU 01000, SLT(I) 01001, SLTU(I) 01010, XOR(I) 01011, OR(I) 01100, AND(I) 01101, SLL(I) 01110, SRL(I) 01111, SRA(I) 10000, SUB 10001, FENCE 10010, unrecognised 11111.
REQ-025 Immsel codes: U 000, J 001, I 010, B 011, S 100, none (R-type, FENCE-free) 101; FENCE uses I with imm forced to 0.
REQ-026 out_imm is fully sign-extended per format; B/J bit 0 is 0; U has low 12 bits 0.
REQ-027 Store opcode is 0100011; loads accept funct3 000/001/010/100/101 only; stores accept 000/001/010 only; branches reject funct3 010/011.
REQ-028 Shifts and ADD/SUB check the full 7-bit funct7 (0000000 or 0100000 where legal); any other value is unrecognised.
REQ-029 State machine RUN/DRAIN/HALTED: accepting opcode 1110011 in RUN moves to DRAIN and is not enqueued; in DRAIN in_ready=0.
REQ-030 DRAIN moves to HALTED on the cycle count==0; halt=1 in HALTED only, held until rst.
REQ-031 An ECALL accepted together with a pop that empties the queue still passes through DRAIN for one cycle.

Reset
REQ-032 On rst: pointers=0, count=0, state=RUN, out_valid=0, halt=0, all stored fields zero; effect is immediate, not clock-gated.
REQ-033 rst during DRAIN or HALTED discards all entries and returns to RUN.

Configuration
REQ-034 Macro DECODE_ILLEGAL_EN: when defined, unrecognised encodings are enqueued with out_alu_op=11111, out_immsel=101, out_illegal=1.
REQ-035 Without DECODE_ILLEGAL_EN: out_illegal is tied 0, unrecognised encodings are dropped (accepted, not enqueued), and no illegal-flag storage exists.

Structure
REQ-036 Package decode_pkg holds ALU-op and immsel constants, opcode constants, and the RUN/DRAIN/HALTED state type.
REQ-037 Sub-module imm_gen (combinational: instr, immsel -> 32-bit imm); the FIFO and FSM stay in decode_queue.

Verification
REQ-038 Push 0x00500093 (ADDI x1,x0,5) into an empty queue -> one cycle later out_valid=1, alu_op 00010, immsel 010, imm 0x00000005, rd 1, rs1 0.
REQ-039 Push 0x402081B3 (SUB x3,x1,x2) then 0xFE000EE3 (BEQ -4) -> alu_op 10001/immsel 101, then alu_op 00011/immsel 011/imm 0xFFFFFFFC.
REQ-040 DEPTH=2, out_ready=0, in_valid held for 3 instructions -> in_ready falls after 2 accepts, count=2; set out_ready=1 -> entries appear in order and pointers wrap.
REQ-041 One entry queued, then push 0x00000073 (ECALL) -> in_ready=0 the next cycle; halt=0 until the entry is popped, then halt=1 and stays 1.
REQ-042 Push 0xFFFFFFFF with DECODE_ILLEGAL_EN -> out_illegal=1, alu_op 11111; without the macro -> count stays 0.
REQ-043 Assert rst mid-DRAIN with 2 entries queued -> count=0, out_valid=0, halt=0, in_ready=1 the next cycle.
